// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//
// Purpose : Definitions shared by the ALU issue controller and its register
//           file: opcode encodings, controller state enum, instruction word
//           field positions and a decode helper.
//
// Contents:
//   OP_*            4-bit opcode encodings (5..14 are illegal)
//   state_t         controller FSM states
//   INSTR_*_LSB     bit positions of the instruction fields
//   instr_t         decoded instruction word
//   decode_instr()  splits a 16-bit word into instr_t
//   op_is_alu()     opcode is executed by the external ALU
//   op_is_legal()   opcode is defined at all
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NUM_REGS = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_CMP = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd15;

    // Instruction word layout: {op, rd, rs1, rs2}
    localparam int INSTR_OP_LSB  = 12;
    localparam int INSTR_RD_LSB  = 8;
    localparam int INSTR_RS1_LSB = 4;
    localparam int INSTR_RS2_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_t;

    function automatic instr_t decode_instr(input logic [15:0] word);
        instr_t d;
        d.op  = word[INSTR_OP_LSB  +: 4];
        d.rd  = word[INSTR_RD_LSB  +: 4];
        d.rs1 = word[INSTR_RS1_LSB +: 4];
        d.rs2 = word[INSTR_RS2_LSB +: 4];
        return d;
    endfunction

    function automatic logic op_is_alu(input logic [3:0] op);
        return (op <= OP_CMP);
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        return op_is_alu(op) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
//
// Purpose : 16 x 16-bit register file for the ALU issue controller. All
//           registers (including R0) are writable. Reads are combinational,
//           the single write port updates on the rising clock edge.
//
// Ports   :
//   clk        in   clock
//   rst        in   asynchronous active-high reset, clears every register
//   rd_addr_a  in   read port A address
//   rd_data_a  out  read port A data
//   rd_addr_b  in   read port B address
//   rd_data_b  out  read port B data
//   dbg_addr   in   debug read address
//   dbg_data   out  debug read data
//   wr_en      in   write enable
//   wr_addr    in   write address
//   wr_data    in   write data
// ---------------------------------------------------------------------------
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose : Strictly serial issue controller for an external combinational
//           ALU. Accepts one instruction at a time, reads its operands from
//           the local register file, gives the ALU ALU_LAT cycles, and writes
//           the result back before the next instruction can be accepted.
//
// Parameters:
//   ALU_LAT      EXEC cycles granted to the ALU before sampling (1..15)
//
// Build option:
//   ALU_DIV_ZERO_CHK_EN  when defined, DIV with a zero divisor is faulted:
//                        EXEC is skipped, no write-back, err pulses with done.
//
// Ports   :
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   instr_valid  in   instruction offered
//   instr_ready  out  controller can accept (IDLE and not in reset)
//   instr        in   {op, rd, rs1, rs2}
//   op_code      out  opcode to ALU (held from accept to next accept)
//   rs1_in       out  first ALU operand (held)
//   rs2_in       out  second ALU operand (held)
//   cin, bin     out  ALU carry/borrow-in, tied low
//   alu_result   in   ALU result
//   done         out  one-cycle retirement pulse
//   err          out  fault pulse, coincident with done
//   dbg_addr     in   debug register read address
//   dbg_data     out  debug register read data (combinational)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for instr_valid; operands read and latched on accept
// EXEC  | ALU evaluating; down-counter runs, result sampled at count zero
// WB    | write captured value to R[rd] unless faulted; done (and err)
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [3:0]  op_code,
    output logic [15:0] rs1_in,
    output logic [15:0] rs2_in,
    output logic        cin,
    output logic        bin,
    input  logic [15:0] alu_result,
    output logic        done,
    output logic        err,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    // Counter is loaded with ALU_LAT-1 so that reaching zero marks the last
    // EXEC cycle.
    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    state_t      state_q;
    state_t      state_nxt;
    instr_t      dec;
    logic        accept;
    logic        div_zero;
    logic        rf_wr_en;
    logic [15:0] rf_rd_a;
    logic [15:0] rf_rd_b;
    logic [3:0]  rd_q;
    logic [15:0] result_q;
    logic        fault_q;
    logic [3:0]  lat_cnt_q;

    assign dec    = decode_instr(instr);
    assign accept = instr_valid && instr_ready;
    assign cin    = 1'b0;
    assign bin    = 1'b0;

`ifdef ALU_DIV_ZERO_CHK_EN
    // Divisor read now is exactly what rs2_in will latch on this accept.
    assign div_zero = (dec.op == OP_DIV) && (rf_rd_b == 16'h0000);
`else
    assign div_zero = 1'b0;
`endif

    alu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (dec.rs1),
        .rd_data_a (rf_rd_a),
        .rd_addr_b (dec.rs2),
        .rd_data_b (rf_rd_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (rf_wr_en),
        .wr_addr   (rd_q),
        .wr_data   (result_q)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_is_alu(dec.op) && !div_zero) begin
                        state_nxt = ST_EXEC;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end
            end
            ST_EXEC: begin
                if (lat_cnt_q == 4'd0) begin
                    state_nxt = ST_WB;
                end
            end
            ST_WB: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        rf_wr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Reset is asynchronous, so state already reads IDLE while rst
                // is high; gate ready explicitly so nothing is offered then.
                instr_ready = !rst;
            end
            ST_WB: begin
                done     = 1'b1;
                err      = fault_q;
                rf_wr_en = !fault_q;
            end
            default: begin
            end
        endcase
    end

    // Operand latch, latency counter and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_code   <= '0;
            rs1_in    <= '0;
            rs2_in    <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            fault_q   <= 1'b0;
            lat_cnt_q <= '0;
        end else begin
            if (accept) begin
                op_code   <= dec.op;
                rs1_in    <= rf_rd_a;
                rs2_in    <= rf_rd_b;
                rd_q      <= dec.rd;
                fault_q   <= !op_is_legal(dec.op) || div_zero;
                lat_cnt_q <= LAT_LOAD;
                // Immediate for LDI; overwritten by the ALU sample for ALU ops
                // and never written back for faulted ones.
                result_q  <= {8'h00, dec.rs1, dec.rs2};
            end else if (state_q == ST_EXEC) begin
                if (lat_cnt_q == 4'd0) begin
                    result_q <= alu_result;
                end else begin
                    lat_cnt_q <= lat_cnt_q - 4'd1;
                end
            end
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, meaning the number of EXEC cycles the combinational ALU is given before its result is sampled (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port instr_valid  input  1  instruction word offered.
REQ-005 SHALL have port instr_ready  output  1  controller can accept an instruction.
REQ-006 SHALL have port instr  input  16  {op[15:12], rd[11:8], rs1[7:4], rs2[3:0]}.
REQ-007 SHALL have port op_code  output  4  opcode driven to ALU.
REQ-008 SHALL have port rs1_in  output  16  first ALU operand.
REQ-009 SHALL have port rs2_in  output  16  second ALU operand.
REQ-010 SHALL have ports cin and bin  output  1 each  ALU carry/borrow-in, constant 0.
REQ-011 SHALL have port alu_result  input  16  ALU result.
REQ-012 SHALL have port done  output  1  one-cycle pulse at instruction retirement.
REQ-013 SHALL have port err  output  1  one-cycle pulse, coincident with done, on a faulted instruction.
REQ-014 SHALL have ports dbg_addr  input  4  and dbg_data  output  16  combinational register-file read port.

Function
REQ-015 SHALL contain a 16 x 16-bit register file R0..R15, all writable.
REQ-016 SHALL use opcodes ADD=0, SUB=1, MUL=2, DIV=3, CMP=4, LDI=15; 5..14 illegal.
REQ-017 SHALL implement FSM states IDLE, EXEC, WB; instr_ready = 1 only in IDLE.
REQ-018 SHALL accept on instr_valid && instr_ready; at accept edge latch op, rd, and register values R[rs1], R[rs2] into op_code/rs1_in/rs2_in.
REQ-019 SHALL transition IDLE->EXEC for ops 0..4, hold EXEC exactly ALU_LAT cycles, capture alu_result on the last EXEC edge, then enter WB.
REQ-020 SHALL, for LDI, transition IDLE->WB and write rd <= {8'h00, rs1, rs2}.
REQ-021 SHALL, for illegal ops, transition IDLE->WB with no register write and assert err.
REQ-022 SHALL, in WB, write the captured value to R[rd] (unless faulted), pulse done, return to IDLE.
REQ-023 SHALL retire ALU ops with done high in cycle T+1+ALU_LAT and LDI/illegal in cycle T+1, T being the accept cycle.
REQ-024 SHALL hold op_code/rs1_in/rs2_in stable from accept until the next accept.
REQ-025 SHALL make a write in WB visible to an instruction accepted in the next IDLE cycle (no hazard; strictly serial).
REQ-026 SHALL ignore instr while instr_ready = 0.
REQ-027 SHALL treat rd equal to rs1/rs2 as legal: operands are read before the write.

Reset
REQ-028 SHALL on rst force state IDLE, all R* = 0, op_code/rs1_in/rs2_in = 0, done = err = 0, cin = bin = 0, and instr_ready = 0 while rst is high.
REQ-029 SHALL abort any in-flight instruction on reset with no register write and no done.

Configuration
REQ-030 SHALL support macro ALU_DIV_ZERO_CHK_EN: when defined, a DIV with latched rs2_in = 0 skips EXEC, goes to WB, suppresses the write, and pulses err; when undefined, DIV by zero executes normally and writes whatever alu_result returns.

Structure
REQ-031 SHALL place opcode encodings, the state enum, and instruction field positions in the shared package alu_pkg.
REQ-032 SHALL implement the register file as sub-module alu_regfile (2 read ports, 1 debug read port, 1 write port, async reset).

Verification
REQ-033 SHALL cover: LDI R1,0x34 then LDI R2,0x12 -> done at T+1 each; dbg R1 = 0x0034, R2 = 0x0012.
REQ-034 SHALL cover: ADD R3,R1,R2 with ALU_LAT = 1 -> op_code = 0, rs1_in = 0x0034, rs2_in = 0x0012, done at T+2, R3 = 0x0046.
REQ-035 SHALL cover: op 7 -> done and err together at T+1; no register changes.
REQ-036 SHALL cover: DIV R4,R1,R0 (R0 = 0) -> with macro, err at T+1 and R4 unchanged; without macro, done at T+2 and R4 = alu_result.
REQ-037 SHALL cover: rst asserted during EXEC of MUL R5 -> R5 = 0, no done, instr_ready = 1 in the first cycle after rst deasserts.
REQ-038 SHALL cover: instr_valid held high for back-to-back ADD R1,R1,R1 -> second accept sees R1 updated by the first (0x0034 -> 0x0068 -> 0x00D0).
